// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer: pulses areset through the pll_slave control register, polls status
// until lock is stable, then enables video. Define PLL_SEQ_MONITOR_EN for lock supervision in RUN.
module pll_lock_sequencer #(
  parameter int RESET_HOLD   = 16,
  parameter int POLL_GAP     = 64,
  parameter int LOCK_STABLE  = 4,
  parameter int LOCK_TIMEOUT = 1024,
  parameter int MON_PERIOD   = 4096
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        restart_i,
  output logic        pll_read,
  output logic        pll_write,
  output logic [1:0]  pll_address,
  output logic [31:0] pll_writedata,
  input  logic [31:0] pll_readdata,
  output logic        video_en,
  output logic        seq_busy,
  output logic        seq_error,
  output logic [7:0]  relock_count
);

  localparam int TMAX01 = (RESET_HOLD > POLL_GAP) ? RESET_HOLD : POLL_GAP;
  localparam int TMAX   = (TMAX01 > MON_PERIOD) ? TMAX01 : MON_PERIOD;
  localparam int TW     = $clog2(TMAX + 1);
  localparam int SW     = $clog2(LOCK_STABLE + 1);
  localparam int PW     = $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_ASSERT, S_HOLD, S_RELEASE, S_GAP, S_READ, S_SAMPLE, S_RUN, S_FAIL
  } state_t;

  state_t        r_state, w_state_nxt;
  logic          r_live;
  logic [TW-1:0] r_tmr, w_tmr_nxt;
  logic [SW-1:0] r_stable, w_stable_nxt;
  logic [PW-1:0] r_poll, w_poll_nxt;
  logic          w_read, w_write;
  logic [31:0]   w_wdata;
  logic          w_locked;
  logic          w_unused_rdata;

  assign w_locked       = pll_readdata[0];
  assign w_unused_rdata = ^pll_readdata[31:1];

`ifdef PLL_SEQ_MONITOR_EN
  logic       r_mon_pend, w_mon_pend_nxt;
  logic [7:0] r_relock, w_relock_nxt;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_tmr_nxt    = r_tmr;
    w_stable_nxt = r_stable;
    w_poll_nxt   = r_poll;
    w_read       = 1'b0;
    w_write      = 1'b0;
    w_wdata      = 32'h0;
`ifdef PLL_SEQ_MONITOR_EN
    w_mon_pend_nxt = 1'b0;
    w_relock_nxt   = r_relock;
`endif
    case (r_state)
      S_ASSERT: begin
        w_write     = 1'b1;
        w_wdata     = 32'h3;
        w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (r_tmr == TW'(RESET_HOLD - 1)) begin
          w_state_nxt = S_RELEASE;
          w_tmr_nxt   = '0;
        end else begin
          w_tmr_nxt = r_tmr + TW'(1);
        end
      end
      S_RELEASE: begin
        w_write     = 1'b1;
        w_wdata     = 32'h2;
        w_state_nxt = S_GAP;
        w_tmr_nxt   = '0;
      end
      S_GAP: begin
        if (r_tmr == TW'(POLL_GAP - 1)) begin
          w_state_nxt = S_READ;
          w_tmr_nxt   = '0;
        end else begin
          w_tmr_nxt = r_tmr + TW'(1);
        end
      end
      S_READ: begin
        w_read      = 1'b1;
        w_state_nxt = S_SAMPLE;
        w_tmr_nxt   = '0;
      end
      S_SAMPLE: begin
        // Read data arrives this cycle (fixed latency 1); every read counts toward the timeout.
        w_poll_nxt   = r_poll + PW'(1);
        w_stable_nxt = w_locked ? r_stable + SW'(1) : '0;
        if (w_locked && r_stable == SW'(LOCK_STABLE - 1))
          w_state_nxt = S_RUN;
        else if (r_poll == PW'(LOCK_TIMEOUT - 1))
          w_state_nxt = S_FAIL;
        else
          w_state_nxt = S_GAP;
      end
      S_RUN: begin
`ifdef PLL_SEQ_MONITOR_EN
        if (r_mon_pend && !w_locked) begin
          w_state_nxt = S_ASSERT;
          if (r_relock != 8'hFF) w_relock_nxt = r_relock + 8'd1;
        end else if (r_tmr == TW'(MON_PERIOD - 1)) begin
          w_read         = 1'b1;
          w_mon_pend_nxt = 1'b1;
          w_tmr_nxt      = '0;
        end else begin
          w_tmr_nxt = r_tmr + TW'(1);
        end
`endif
      end
      default: ;
    endcase
    // Strobes come from the current state, so a restart never cuts a transfer short.
    if (restart_i || !r_live) w_state_nxt = S_ASSERT;
    if (w_state_nxt == S_ASSERT) begin
      w_tmr_nxt    = '0;
      w_stable_nxt = '0;
      w_poll_nxt   = '0;
`ifdef PLL_SEQ_MONITOR_EN
      w_mon_pend_nxt = 1'b0;
`endif
    end
  end

  // r_live keeps the bus quiet until the first edge after reset release.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state  <= S_ASSERT;
      r_live   <= 1'b0;
      r_tmr    <= '0;
      r_stable <= '0;
      r_poll   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_live   <= 1'b1;
      r_tmr    <= w_tmr_nxt;
      r_stable <= w_stable_nxt;
      r_poll   <= w_poll_nxt;
    end
  end

`ifdef PLL_SEQ_MONITOR_EN
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_mon_pend <= 1'b0;
      r_relock   <= 8'd0;
    end else begin
      r_mon_pend <= w_mon_pend_nxt;
      r_relock   <= w_relock_nxt;
    end
  end
  assign relock_count = r_relock;
`else
  assign relock_count = 8'd0;
`endif

  assign pll_read      = r_live & w_read;
  assign pll_write     = r_live & w_write;
  assign pll_address   = pll_write ? 2'd1 : 2'd0;
  assign pll_writedata = pll_write ? w_wdata : 32'h0;
  assign video_en      = (r_state == S_RUN);
  assign seq_busy      = r_live & (r_state != S_RUN) & (r_state != S_FAIL);
  assign seq_error     = (r_state == S_FAIL);

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: PLL slave model with scripted/random lock patterns,
// transaction log, and a window-based prediction of read count and outcome.
module tb_pll_lock_sequencer;
  localparam int RH = 5, PG = 3, LS = 4, LT = 8, MP = 20;

  logic        clk, rst_n, restart;
  logic        pll_read, pll_write;
  logic [1:0]  addr;
  logic [31:0] wdata, rdata, rnd;
  logic        video_en, seq_busy, seq_error;
  logic [7:0]  relock;

  int n_assert = 0, n_fail = 0, cyc = 0;
  int wr_cyc[$], rd_cyc[$];
  logic [31:0] wr_dat[$];
  int wr_base = 0, rd_base = 0, r0, w0;
  bit lk_arr[0:31];
  int lk_len = 0;
  bit lk_def = 0;
  bit resp_cyc, apply_lk, held_lk, last_lk;

  pll_lock_sequencer #(.RESET_HOLD(RH), .POLL_GAP(PG), .LOCK_STABLE(LS),
                       .LOCK_TIMEOUT(LT), .MON_PERIOD(MP)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .restart_i(restart),
    .pll_read(pll_read), .pll_write(pll_write), .pll_address(addr),
    .pll_writedata(wdata), .pll_readdata(rdata), .video_en(video_en),
    .seq_busy(seq_busy), .seq_error(seq_error), .relock_count(relock));

  initial begin clk = 0; forever #5 clk = ~clk; end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit lk_at(input int i);
    if (i < 0) return 1'b0;
    return (i < lk_len) ? lk_arr[i] : lk_def;
  endfunction

  // Outcome: the first window of LS consecutive locked reads within the first LT reads wins.
  function automatic void predict(output int n, output bit ok);
    bit all1;
    n = LT; ok = 1'b0;
    for (int e = LS - 1; e < LT; e++) begin
      all1 = 1'b1;
      for (int k = e - LS + 1; k <= e; k++) all1 &= lk_at(k);
      if (all1) begin n = e + 1; ok = 1'b1; return; end
    end
  endfunction

  // Slave: status response one cycle after the read strobe, garbage otherwise.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rnd = $urandom;
    if (pll_read) rnd[0] = lk_at(rd_cyc.size() - 1 - rd_base);
    rdata <= rnd;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      resp_cyc = 0; apply_lk = 0; last_lk = 0;
    end else begin
      if (apply_lk) last_lk = held_lk;
      apply_lk = 0;
      if (resp_cyc) begin held_lk = rdata[0]; apply_lk = 1; end
      resp_cyc = pll_read;
      if (pll_write) begin
        wr_cyc.push_back(cyc); wr_dat.push_back(wdata);
        chk("wr_addr", {30'd0, addr}, 32'd1);
      end
      if (pll_read) begin
        rd_cyc.push_back(cyc);
        chk("rd_addr", {30'd0, addr}, 32'd0);
      end
      chk("one_strobe", {31'd0, pll_read & pll_write}, 32'd0);
      if (video_en) chk("video_vs_lock", {31'd0, last_lk}, 32'd1);
    end
  end

  task automatic tick; @(negedge clk); #1; endtask
  task automatic clear_logs; wr_base = wr_cyc.size(); rd_base = rd_cyc.size(); endtask

  task automatic pulse_restart;
    clear_logs();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("rs_err", {31'd0, seq_error}, 32'd0);
    chk("rs_video", {31'd0, video_en}, 32'd0);
    chk("rs_busy", {31'd0, seq_busy}, 32'd1);
    chk("rs_wr3", (wr_cyc.size() - wr_base == 1) ? {31'd0, wr_dat[wr_base] == 32'h3 && wr_cyc[wr_base] == cyc} : 32'hDEAD, 32'd1);
  endtask

  task automatic run_seq(input string tag);
    int n, nr, nw, last;
    bit ok, done, gap_ok;
    predict(n, ok);
    done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      tick();
      if (video_en || seq_error) done = 1;
    end
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    nw = wr_cyc.size() - wr_base;
    nr = rd_cyc.size() - rd_base;
    chk({tag, "_nwrites"}, nw, 2);
    chk({tag, "_nreads"}, nr, n);
    if (nw == 2) begin
      chk({tag, "_wr0"}, wr_dat[wr_base], 32'h3);
      chk({tag, "_wr1"}, wr_dat[wr_base + 1], 32'h2);
      chk({tag, "_hold"}, wr_cyc[wr_base + 1] - wr_cyc[wr_base], RH + 1);
      if (nr > 0) chk({tag, "_gap0"}, rd_cyc[rd_base] - wr_cyc[wr_base + 1], PG + 1);
    end
    if (nr > 0) begin
      gap_ok = 1;
      for (int i = rd_base + 1; i < rd_cyc.size(); i++)
        if (rd_cyc[i] - rd_cyc[i - 1] != PG + 2) gap_ok = 0;
      chk({tag, "_gaps"}, {31'd0, gap_ok}, 32'd1);
      last = rd_cyc[rd_cyc.size() - 1];
      chk({tag, "_latency"}, cyc - last, 2);
    end
    chk({tag, "_video"}, {31'd0, video_en}, {31'd0, ok});
    chk({tag, "_error"}, {31'd0, seq_error}, {31'd0, !ok});
    chk({tag, "_busy"}, {31'd0, seq_busy}, 32'd0);
  endtask

  initial begin
    bit fell;
    restart = 0; rst_n = 0;
    repeat (3) tick();
    chk("rst_read", {31'd0, pll_read}, 0);
    chk("rst_write", {31'd0, pll_write}, 0);
    chk("rst_addr", {30'd0, addr}, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_video", {31'd0, video_en}, 0);
    chk("rst_busy", {31'd0, seq_busy}, 0);
    chk("rst_error", {31'd0, seq_error}, 0);
    chk("rst_relock", {24'd0, relock}, 0);

    // 1: three unlocked reads, then locked
    lk_len = 3; lk_arr[0] = 0; lk_arr[1] = 0; lk_arr[2] = 0; lk_def = 1;
    clear_logs();
    rst_n = 1;
    run_seq("t1");

`ifdef PLL_SEQ_MONITOR_EN
    r0 = rd_cyc.size();
    repeat (2 * MP + 5) tick();
    chk("mon_reads", rd_cyc.size() - r0, 2);
    if (rd_cyc.size() - r0 == 2) chk("mon_period", rd_cyc[r0 + 1] - rd_cyc[r0], MP);
    chk("mon_video", {31'd0, video_en}, 1);
    chk("mon_relock0", {24'd0, relock}, 0);
    lk_def = 0;
    fell = 0;
    for (int i = 0; i < 3 * MP && !fell; i++) begin tick(); if (!video_en) fell = 1; end
    chk("loss_fell", {31'd0, fell}, 1);
    chk("loss_relock", {24'd0, relock}, 1);
    chk("loss_sample_edge", cyc - rd_cyc[rd_cyc.size() - 1], 2);
    chk("loss_wr3", wr_dat[wr_dat.size() - 1], 32'h3);
    chk("loss_wr3_cyc", wr_cyc[wr_cyc.size() - 1], cyc);
    lk_def = 1;
`else
    r0 = rd_cyc.size(); w0 = wr_cyc.size();
    lk_def = 0;
    repeat (2 * MP + 5) tick();
    chk("run_noreads", rd_cyc.size() - r0, 0);
    chk("run_nowrites", wr_cyc.size() - w0, 0);
    chk("run_video", {31'd0, video_en}, 1);
    chk("run_relock", {24'd0, relock}, 0);
`endif

    // 2: never locks -> timeout
    lk_len = 0; lk_def = 0;
    pulse_restart();
    run_seq("t2");
    r0 = rd_cyc.size(); w0 = wr_cyc.size();
    repeat (40) tick();
    chk("fail_noreads", rd_cyc.size() - r0, 0);
    chk("fail_nowrites", wr_cyc.size() - w0, 0);
    chk("fail_sticky", {31'd0, seq_error}, 1);
    chk("fail_video", {31'd0, video_en}, 0);

    // 3 (restart out of FAIL): broken lock run
    lk_len = 7; lk_def = 1;
    lk_arr[0] = 1; lk_arr[1] = 1; lk_arr[2] = 0; lk_arr[3] = 1;
    lk_arr[4] = 1; lk_arr[5] = 1; lk_arr[6] = 1;
    pulse_restart();
    run_seq("t3");

    // 5: restart while in HOLD
    lk_len = 0; lk_def = 1;
    pulse_restart();
    tick(); tick();
    pulse_restart();
    run_seq("t5");

    // 6: reset during HOLD
    lk_len = 2; lk_arr[0] = 1; lk_arr[1] = 0; lk_def = 1;
    pulse_restart();
    tick(); tick();
    rst_n = 0;
    #1;
    chk("arst_busy", {31'd0, seq_busy}, 0);
    chk("arst_write", {31'd0, pll_write}, 0);
    chk("arst_video", {31'd0, video_en}, 0);
    chk("arst_error", {31'd0, seq_error}, 0);
    chk("arst_relock", {24'd0, relock}, 0);
    tick();
    clear_logs();
    rst_n = 1;
    run_seq("t6");

    // random lock patterns
    for (int it = 0; it < 8; it++) begin
      lk_len = $urandom_range(4, 12);
      for (int k = 0; k < lk_len; k++) lk_arr[k] = ($urandom_range(0, 3) != 0);
      lk_def = $urandom_range(0, 1);
      pulse_restart();
      run_seq("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
